tile_sad_router: RTL and testbench

- Streaming successor to the fixed-size SAD workload allocator. Consumes raster-ordered tile pixels from the BRAM tile interface over a valid/ready handshake.
- Computes a per-tile horizontal-gradient SAD and decides per tile whether to route to the CNN path or the alternate path.
- Queues decisions in a small FIFO with backpressure so a stalled consumer never loses a decision.
- Replaces the hard-coded counter/valid gluing between BRAM and allocator in the top level.

---
 rtl/tile_sad_router.sv | 207 ++++++++++++++++++++
 tb/tb_tile_sad_router.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_sad_router.sv
// tile_sad_router
// Streams raster-ordered tile pixels, accumulates a saturating horizontal
// gradient SAD per tile and queues a routing decision per tile
// ({route, SAD, tile index}) in a show-ahead FIFO.
//
// Ports:
//   iClk, iRst   clock, synchronous active-high reset
//   iData        pixel, raster order within the tile
//   iValid       pixel offered
//   oReady       pixel accepted on an edge where iValid & oReady
//   iThreshold   routing threshold, latched on the first pixel of each tile
//   oDecValid    decision FIFO head valid
//   iDecReady    head popped on an edge where oDecValid & iDecReady
//   oRouteToCnn  head decision: 1 = CNN path, 0 = alternate path
//   oSad         head tile SAD
//   oTileIdx     head tile index
//   oCntCnn      tiles routed to CNN     (TILE_STATS_EN only, else 0)
//   oCntAlt      tiles routed to alternate (TILE_STATS_EN only, else 0)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends combinationally on the opposite valid/ready.
//
// Optional feature: define TILE_STATS_EN to build the saturating route
// counters; without it oCntCnn/oCntAlt are constant 0.
module tile_sad_router #(
    parameter int DATA_WIDTH     = 8,
    parameter int TILE_WIDTH     = 16,
    parameter int TILE_HEIGHT    = 16,
    parameter int SAD_WIDTH      = 20,
    parameter int DEC_FIFO_DEPTH = 4,
    parameter int IDX_WIDTH      = 16
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [SAD_WIDTH-1:0]  iThreshold,
    output logic                  oDecValid,
    input  logic                  iDecReady,
    output logic                  oRouteToCnn,
    output logic [SAD_WIDTH-1:0]  oSad,
    output logic [IDX_WIDTH-1:0]  oTileIdx,
    output logic [15:0]           oCntCnn,
    output logic [15:0]           oCntAlt
);

    localparam int COL_W   = (TILE_WIDTH  > 1) ? $clog2(TILE_WIDTH)  : 1;
    localparam int ROW_W   = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
    localparam int PTR_W   = $clog2(DEC_FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + SAD_WIDTH + IDX_WIDTH;
    localparam int SUM_W   = ((SAD_WIDTH > DATA_WIDTH) ? SAD_WIDTH : DATA_WIDTH) + 1;
    localparam logic [SAD_WIDTH-1:0] SAD_MAX = {SAD_WIDTH{1'b1}};

    // Pixel position within the tile
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_last, row_last, offer_last, offer_first, accept;

    assign col_last    = (col == COL_W'(TILE_WIDTH - 1));
    assign row_last    = (row == ROW_W'(TILE_HEIGHT - 1));
    assign offer_last  = col_last && row_last;
    assign offer_first = (col == '0) && (row == '0);
    assign accept      = iValid && oReady;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Previous accepted pixel and per-tile threshold
    logic [DATA_WIDTH-1:0] prev_pix;
    logic [SAD_WIDTH-1:0]  thr_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            prev_pix <= '0;
            thr_q    <= '0;
        end else if (accept) begin
            prev_pix <= iData;
            if (offer_first) thr_q <= iThreshold;
        end
    end

    // Stage 1: registered pixel context
    logic                  s1_valid, s1_row_first, s1_tile_first, s1_last;
    logic [DATA_WIDTH-1:0] s1_pix, s1_prev;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1_valid      <= 1'b0;
            s1_row_first  <= 1'b0;
            s1_tile_first <= 1'b0;
            s1_last       <= 1'b0;
            s1_pix        <= '0;
            s1_prev       <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_pix        <= iData;
                s1_prev       <= prev_pix;
                s1_row_first  <= (col == '0);
                s1_tile_first <= offer_first;
                s1_last       <= offer_last;
            end
        end
    end

    // Stage 2: absolute difference and saturating accumulation
    logic [DATA_WIDTH-1:0] diff;
    logic [SAD_WIDTH-1:0]  acc, base, sad_next;
    logic [SUM_W-1:0]      sum;
    logic                  route_next, push, pop;

    always_comb begin
        diff = '0;
        if (!s1_row_first)
            diff = (s1_pix >= s1_prev) ? (s1_pix - s1_prev) : (s1_prev - s1_pix);
        base       = s1_tile_first ? '0 : acc;
        sum        = SUM_W'(base) + SUM_W'(diff);
        sad_next   = (sum > SUM_W'(SAD_MAX)) ? SAD_MAX : sum[SAD_WIDTH-1:0];
        // Equality goes to the alternate path
        route_next = (sad_next > thr_q);
    end

    always_ff @(posedge iClk) begin
        if (iRst)          acc <= '0;
        else if (s1_valid) acc <= sad_next;
    end

    // Decision FIFO (show-ahead)
    logic [ENTRY_W-1:0]   mem [DEC_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count, free, pending;
    logic [IDX_WIDTH-1:0] tile_idx;

    assign push = s1_valid && s1_last;
    assign pop  = oDecValid && iDecReady;

    always_ff @(posedge iClk) begin
        if (push) mem[wr_ptr] <= {route_next, sad_next, tile_idx};
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tile_idx <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                tile_idx <= tile_idx + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign oDecValid = (count != '0);
    assign {oRouteToCnn, oSad, oTileIdx} = oDecValid ? mem[rd_ptr] : '0;

    // Only a tile's last pixel can need a FIFO slot. A tile end still sitting
    // in stage 1 has a slot reserved, so it counts against the free space.
    // Ready comes from registered state only: a pop frees a slot next cycle.
    assign free    = CNT_W'(DEC_FIFO_DEPTH) - count;
    assign pending = CNT_W'(push);
    assign oReady  = !(offer_last && (free <= pending));

`ifdef TILE_STATS_EN
    logic [15:0] cnt_cnn, cnt_alt;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_cnn <= '0;
            cnt_alt <= '0;
        end else if (push) begin
            if (route_next) begin
                if (cnt_cnn != 16'hFFFF) cnt_cnn <= cnt_cnn + 1'b1;
            end else begin
                if (cnt_alt != 16'hFFFF) cnt_alt <= cnt_alt + 1'b1;
            end
        end
    end

    assign oCntCnn = cnt_cnn;
    assign oCntAlt = cnt_alt;
`else
    assign oCntCnn = '0;
    assign oCntAlt = '0;
`endif

endmodule

// File: tb/tb_tile_sad_router.sv
// Directed bench for tile_sad_router (16x16 tiles, 4-entry FIFO).
// A second instance with a 12-bit SAD shares the pixel stream to exercise
// accumulator saturation.
module tb_tile_sad_router;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [7:0]  iData;
    logic        iValid;
    logic        oReady;
    logic [19:0] iThreshold;
    logic        oDecValid;
    logic        iDecReady;
    logic        oRouteToCnn;
    logic [19:0] oSad;
    logic [15:0] oTileIdx;
    logic [15:0] oCntCnn, oCntAlt;

    logic        sat_ready, sat_dec_valid, sat_route;
    logic [11:0] sat_sad;
    logic [15:0] sat_idx, sat_cnn, sat_alt;

    int vectors     = 0;
    int miscompares = 0;

    logic        sat_seen = 1'b0;
    logic [11:0] sat_sad_cap = '0;
    logic        sat_route_cap = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 iClk = ~iClk;

    tile_sad_router dut (
        .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid), .oReady(oReady),
        .iThreshold(iThreshold), .oDecValid(oDecValid), .iDecReady(iDecReady),
        .oRouteToCnn(oRouteToCnn), .oSad(oSad), .oTileIdx(oTileIdx),
        .oCntCnn(oCntCnn), .oCntAlt(oCntAlt)
    );

    tile_sad_router #(.SAD_WIDTH(12)) u_sat (
        .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid), .oReady(sat_ready),
        .iThreshold(iThreshold[11:0]), .oDecValid(sat_dec_valid), .iDecReady(1'b1),
        .oRouteToCnn(sat_route), .oSad(sat_sad), .oTileIdx(sat_idx),
        .oCntCnn(sat_cnn), .oCntAlt(sat_alt)
    );

    // The saturating instance pops every decision at once; capture tile 2.
    always @(posedge iClk) begin
        if (sat_dec_valid && sat_idx == 16'd2) begin
            sat_seen      <= 1'b1;
            sat_sad_cap   <= sat_sad;
            sat_route_cap <= sat_route;
        end
    end

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [7:0] px(input int kind, input int r, input int c);
        logic [7:0] v;
        case (kind)
            0:       v = 8'h5A;                              // constant
            1:       v = (c % 2 == 1) ? 8'd255 : 8'd0;       // alternating
            default: v = (r == 0) ? ((c % 2 == 1) ? 8'd255 : 8'd0) : 8'd7;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Offer one pixel and hold it until accepted (bounded).
    task automatic send_px(input logic [7:0] d);
        int n = 0;
        iData  = d;
        iValid = 1'b1;
        while (!oReady && n < 50) begin
            tick();
            n++;
        end
        if (!oReady) check("px_ready_timeout", {31'd0, oReady}, 32'd1);
        tick();
        iValid = 1'b0;
    endtask

    task automatic send_tile(input int kind, input logic [19:0] thr,
                             input logic [19:0] thr_mid, input int npix);
        iThreshold = thr;
        for (int p = 0; p < npix; p++) begin
            send_px(px(kind, p / 16, p % 16));
            if (p == 5) iThreshold = thr_mid;
        end
    endtask

    task automatic wait_dec();
        int n = 0;
        while (!oDecValid && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Wait for a decision, compare the head, pop it.
    task automatic expect_dec(input string pfx, input logic route,
                              input logic [19:0] sad, input logic [15:0] idx);
        wait_dec();
        check({pfx, ".valid"}, {31'd0, oDecValid}, 32'd1);
        check({pfx, ".route"}, {31'd0, oRouteToCnn}, {31'd0, route});
        check({pfx, ".sad"},   {12'd0, oSad}, {12'd0, sad});
        check({pfx, ".idx"},   {16'd0, oTileIdx}, {16'd0, idx});
        iDecReady = 1'b1;
        tick();
        iDecReady = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        iRst       = 1'b1;
        iData      = '0;
        iValid     = 1'b0;
        iThreshold = '0;
        iDecReady  = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;

        // Reset state
        check("rst.ready",  {31'd0, oReady}, 32'd1);
        check("rst.valid",  {31'd0, oDecValid}, 32'd0);
        check("rst.route",  {31'd0, oRouteToCnn}, 32'd0);
        check("rst.sad",    {12'd0, oSad}, 32'd0);
        check("rst.idx",    {16'd0, oTileIdx}, 32'd0);
        check("rst.cnn",    {16'd0, oCntCnn}, 32'd0);
        check("rst.alt",    {16'd0, oCntAlt}, 32'd0);

        // Constant tile: SAD 0, decision visible on the second edge after
        // the last accept.
        send_tile(0, 20'd6000, 20'd6000, 256);
        check("const.lat_early", {31'd0, oDecValid}, 32'd0);
        tick();
        check("const.lat", {31'd0, oDecValid}, 32'd1);
        expect_dec("const", 1'b0, 20'd0, 16'd0);
        check("const.empty", {31'd0, oDecValid}, 32'd0);

        // Alternating tile: 16 rows x 15 diffs x 255
        send_tile(1, 20'd6000, 20'd6000, 256);
        expect_dec("alt", 1'b1, 20'd61200, 16'd1);

        // Saturation: 12-bit instance clamps at 4095, 4095 > 4000
        send_tile(1, 20'd4000, 20'd4000, 256);
        expect_dec("sat_main", 1'b1, 20'd61200, 16'd2);
        tick();
        check("sat.seen",  {31'd0, sat_seen}, 32'd1);
        check("sat.sad",   {20'd0, sat_sad_cap}, 32'd4095);
        check("sat.route", {31'd0, sat_route_cap}, 32'd1);

        // Threshold equality (15 x 255 = 3825); mid-tile threshold changes
        // must be ignored.
        send_tile(2, 20'd3825, 20'd0, 256);
        expect_dec("eq", 1'b0, 20'd3825, 16'd3);
        send_tile(2, 20'd3824, 20'd60000, 256);
        expect_dec("eq_m1", 1'b1, 20'd3825, 16'd4);

        // Backpressure: four tiles fill the FIFO, fifth tile stalls on its
        // last pixel only.
        for (int t = 0; t < 4; t++) send_tile(1, 20'd6000, 20'd6000, 256);
        send_tile(1, 20'd6000, 20'd6000, 255);
        iData  = px(1, 15, 15);
        iValid = 1'b1;
        repeat (3) tick();
        check("bp.stall",     {31'd0, oReady}, 32'd0);
        check("bp.full_valid", {31'd0, oDecValid}, 32'd1);
        check("bp.head_idx",  {16'd0, oTileIdx}, 32'd5);
        iDecReady = 1'b1;
        #1;
        check("bp.no_thru",   {31'd0, oReady}, 32'd0);
        tick();
        iDecReady = 1'b0;
        check("bp.freed",     {31'd0, oReady}, 32'd1);
        tick();
        iValid = 1'b0;
        tick();
        for (int i = 6; i <= 9; i++) expect_dec($sformatf("bp%0d", i), 1'b1, 20'd61200, 16'(i));
        check("bp.drained", {31'd0, oDecValid}, 32'd0);

`ifdef TILE_STATS_EN
        check("stats.cnn", {16'd0, oCntCnn}, 32'd8);
        check("stats.alt", {16'd0, oCntAlt}, 32'd2);
`else
        check("stats.cnn", {16'd0, oCntCnn}, 32'd0);
        check("stats.alt", {16'd0, oCntAlt}, 32'd0);
`endif

        // Reset mid-tile: partial tile discarded, index restarts at 0
        for (int p = 0; p < 100; p++) send_px(px(1, p / 16, p % 16));
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        check("mrst.ready", {31'd0, oReady}, 32'd1);
        check("mrst.valid", {31'd0, oDecValid}, 32'd0);
        check("mrst.cnn",   {16'd0, oCntCnn}, 32'd0);
        check("mrst.alt",   {16'd0, oCntAlt}, 32'd0);
        send_tile(0, 20'd6000, 20'd6000, 256);
        expect_dec("mrst", 1'b0, 20'd0, 16'd0);
        repeat (10) tick();
        check("mrst.single", {31'd0, oDecValid}, 32'd0);
`ifdef TILE_STATS_EN
        check("mrst.cnn_end", {16'd0, oCntCnn}, 32'd0);
        check("mrst.alt_end", {16'd0, oCntAlt}, 32'd1);
`else
        check("mrst.cnn_end", {16'd0, oCntCnn}, 32'd0);
        check("mrst.alt_end", {16'd0, oCntAlt}, 32'd0);
`endif

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
